// File: rtl/rs_syndrome_chk.sv
// Reed-Solomon receive-side syndrome checker: Horner evaluation of the received
// codeword at the 2*TT consecutive roots, then serial syndrome dump with error flag.
module rs_syndrome_chk #(
  parameter int TT   = 3,
  parameter int NN   = 15,
  parameter int MM   = 4,
  parameter int PRIM = 19,
  parameter int FCR  = 1
) (
  input  logic          CLK,
  input  logic          NGRST,
  input  logic          RST,
  input  logic          CLKEN,
  input  logic          START,
  input  logic [MM-1:0] DATAINP,
  output logic          RFS,
  output logic          RFD,
  output logic          RDY,
  output logic [MM-1:0] SYNDOUT,
  output logic          DONE,
  output logic          ERRDET
);

  localparam int NS = 2 * TT;
  localparam int CW = $clog2((NN > NS) ? NN : NS);
  localparam logic [MM-1:0] PRIM_LO = PRIM[MM-1:0];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;

  function automatic logic [MM-1:0] gf_xtime(input logic [MM-1:0] a);
    logic [MM-1:0] sh;
    sh = {a[MM-2:0], 1'b0};
    return a[MM-1] ? (sh ^ PRIM_LO) : sh;
  endfunction

  // Called only with constant k, so the loop unrolls into a fixed XOR network.
  function automatic logic [MM-1:0] gf_mul_pow(input logic [MM-1:0] a, input int k);
    logic [MM-1:0] r;
    r = a;
    for (int i = 0; i < k; i++) begin
      r = gf_xtime(r);
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MM-1:0] s_q [NS];
  logic [MM-1:0] s_d [NS];
  logic [MM-1:0] s_mul [NS];
  logic [MM-1:0] sel;
  logic          rfs_q, rfs_d;
  logic          rfd_q, rfd_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [MM-1:0] synd_q, synd_d;

  for (genvar gi = 0; gi < NS; gi++) begin : g_mul
    assign s_mul[gi] = gf_mul_pow(s_q[gi], FCR + gi);
  end

  always_comb begin
    sel = '0;
    for (int j = 0; j < NS; j++) begin
      if (cnt_q == CW'(j)) sel = s_q[j];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    rfs_d   = rfs_q;
    rfd_d   = rfd_q;
    rdy_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    synd_d  = synd_q;
    if (RST) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      for (int j = 0; j < NS; j++) s_d[j] = '0;
      rfs_d   = 1'b1;
      rfd_d   = 1'b0;
      err_d   = 1'b0;
      synd_d  = '0;
    end else if (CLKEN) begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            for (int j = 0; j < NS; j++) s_d[j] = DATAINP;
            cnt_d   = CW'(1);
            err_d   = 1'b0;
            rfs_d   = 1'b0;
            rfd_d   = 1'b1;
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          for (int j = 0; j < NS; j++) s_d[j] = s_mul[j] ^ DATAINP;
          if (cnt_q == CW'(NN - 1)) begin
            cnt_d   = '0;
            rfd_d   = 1'b0;
            state_d = ST_DUMP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DUMP: begin
          synd_d = sel;
          rdy_d  = 1'b1;
          err_d  = err_q | (|sel);
          if (cnt_q == CW'(NS - 1)) begin
            done_d  = 1'b1;
            rfs_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rfs_d   = 1'b1;
          rfd_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int j = 0; j < NS; j++) s_q[j] <= '0;
      rfs_q   <= 1'b1;
      rfd_q   <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      synd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int j = 0; j < NS; j++) s_q[j] <= s_d[j];
      rfs_q   <= rfs_d;
      rfd_q   <= rfd_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      synd_q  <= synd_d;
    end
  end

  assign RFS     = rfs_q;
  assign RFD     = rfd_q;
  assign RDY     = rdy_q;
  assign DONE    = done_q;
  assign ERRDET  = err_q;
  assign SYNDOUT = synd_q;

endmodule

// File: tb/tb_rs_syndrome_chk.sv
// Scoreboard bench for rs_syndrome_chk: stimulus pushes expected syndromes,
// a forked monitor pops and compares on every RDY.
module tb_rs_syndrome_chk;

  localparam int NN = 15;
  localparam int NS = 6;

  typedef logic [3:0] sym_t;
  typedef sym_t frame_t [NN];
  typedef struct packed {
    logic [3:0] s;
    logic       last;
    logic       err;
  } exp_t;

  logic       CLK = 1'b0;
  logic       NGRST, RST, CLKEN, START;
  logic [3:0] DATAINP;
  logic       RFS, RFD, RDY, DONE, ERRDET;
  logic [3:0] SYNDOUT;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic en_at_edge = 1'b0;
  sym_t gpoly [7];

  rs_syndrome_chk dut (
    .CLK(CLK), .NGRST(NGRST), .RST(RST), .CLKEN(CLKEN), .START(START),
    .DATAINP(DATAINP), .RFS(RFS), .RFD(RFD), .RDY(RDY), .SYNDOUT(SYNDOUT),
    .DONE(DONE), .ERRDET(ERRDET)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) en_at_edge <= CLKEN;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic sym_t xt(input sym_t a);
    return a[3] ? ({a[2:0], 1'b0} ^ 4'h3) : {a[2:0], 1'b0};
  endfunction

  function automatic sym_t gmul(input sym_t a, input sym_t b);
    sym_t p = '0;
    sym_t aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic sym_t apow(input int e);
    sym_t r = 4'h1;
    for (int i = 0; i < e % 15; i++) r = xt(r);
    return r;
  endfunction

  // Direct power-sum evaluation: S_j = sum r_i * alpha^((1+j)*deg_i).
  function automatic sym_t syn_model(input frame_t f, input int j);
    sym_t s = '0;
    for (int i = 0; i < NN; i++) s ^= gmul(f[i], apow((1 + j) * (NN - 1 - i)));
    return s;
  endfunction

  function automatic frame_t mk_codeword(input sym_t m [9]);
    sym_t   c [NN];
    frame_t f;
    for (int k = 0; k < NN; k++) c[k] = '0;
    for (int a = 0; a < 9; a++)
      for (int b = 0; b < 7; b++) c[a + b] ^= gmul(m[a], gpoly[b]);
    for (int i = 0; i < NN; i++) f[i] = c[NN - 1 - i];
    return f;
  endfunction

  task automatic cyc(input logic en, input logic st, input sym_t d);
    CLKEN = en; START = st; DATAINP = d;
    @(negedge CLK);
  endtask

  // exp_s: expected syndromes (hand values or model); n_dump limits the dump phase.
  task automatic send_frame(input frame_t f, input sym_t exp_s [NS], input bit throttle,
                            input int n_dump, input int start_mid);
    logic err = 1'b0;
    int   i = 0;
    int   k = 0;
    logic en;
    for (int j = 0; j < NS; j++) err |= (exp_s[j] != 0);
    for (int j = 0; j < n_dump; j++) exp_q.push_back('{exp_s[j], j == NS - 1, err});
    while (i < NN) begin
      en = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(en, (i == 0) || (i == start_mid), en ? f[i] : sym_t'($urandom));
      if (en) i++;
    end
    while (k < n_dump) begin
      en = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(en, 1'($urandom_range(0, 1)), sym_t'($urandom));
      if (en) k++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (NGRST) begin
        if (RDY && !en_at_edge) check("rdy_while_clken_low", 1, 0);
        if (DONE && !en_at_edge) check("done_while_clken_low", 1, 0);
        if (RDY) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rdy", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("syndout", int'(SYNDOUT), int'(e.s));
            check("done_flag", int'(DONE), int'(e.last));
            if (e.last) check("errdet", int'(ERRDET), int'(e.err));
          end
        end else if (DONE) begin
          check("done_without_rdy", 1, 0);
        end
      end
    end
  endtask

  frame_t f, cwf;
  sym_t   es [NS];
  sym_t   msg [9];
  sym_t   root;

  initial begin
    NGRST = 1'b0; RST = 1'b0; CLKEN = 1'b0; START = 1'b0; DATAINP = '0;
    gpoly[0] = 4'h1;
    for (int k = 1; k < 7; k++) gpoly[k] = '0;
    for (int j = 0; j < NS; j++) begin
      root = apow(1 + j);
      for (int k = j + 1; k >= 1; k--) gpoly[k] = gpoly[k - 1] ^ gmul(gpoly[k], root);
      gpoly[0] = gmul(gpoly[0], root);
    end
    fork monitor(); join_none

    repeat (2) @(negedge CLK);
    check("rst_rfs", int'(RFS), 1);
    check("rst_rfd", int'(RFD), 0);
    check("rst_rdy", int'(RDY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_errdet", int'(ERRDET), 0);
    check("rst_syndout", int'(SYNDOUT), 0);
    NGRST = 1'b1;
    @(negedge CLK);

    // All-zero codeword
    for (int i = 0; i < NN; i++) f[i] = '0;
    es = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    send_frame(f, es, 1'b0, NS, -1);
    // Single error at degree 1
    f[13] = 4'd1;
    es = '{4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12};
    send_frame(f, es, 1'b0, NS, -1);
    // Error at degree 0
    f[13] = 4'd0; f[14] = 4'd1;
    es = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    send_frame(f, es, 1'b0, NS, -1);
    // Error at degree 14: alpha^14, alpha^28, ... alpha^84
    f[14] = 4'd0; f[0] = 4'd1;
    es = '{4'd9, 4'd13, 4'd15, 4'd14, 4'd7, 4'd10};
    send_frame(f, es, 1'b0, NS, -1);
    // Same frame throttled, with START raised mid-ACC
    send_frame(f, es, 1'b1, NS, 5);

    // Codeword loopback, back-to-back at minimum spacing
    es = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int n = 0; n < 1000; n++) begin
      for (int a = 0; a < 9; a++) msg[a] = sym_t'($urandom);
      cwf = mk_codeword(msg);
      send_frame(cwf, es, 1'b0, NS, -1);
    end
    // Throttled loopback and throttled random-error frames
    for (int n = 0; n < 10; n++) begin
      for (int a = 0; a < 9; a++) msg[a] = sym_t'($urandom);
      cwf = mk_codeword(msg);
      es = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      send_frame(cwf, es, 1'b1, NS, -1);
      cwf[$urandom_range(0, NN - 1)] ^= sym_t'($urandom_range(1, 15));
      for (int j = 0; j < NS; j++) es[j] = syn_model(cwf, j);
      send_frame(cwf, es, 1'b1, NS, 7);
    end

    // RST at symbol 7 with CLKEN low: partial frame discarded
    for (int i = 0; i < 7; i++) cyc(1'b1, i == 0, sym_t'(i + 3));
    check("acc_rfd", int'(RFD), 1);
    check("acc_rfs", int'(RFS), 0);
    RST = 1'b1;
    cyc(1'b0, 1'b1, 4'd5);
    RST = 1'b0;
    check("midrst_rfs", int'(RFS), 1);
    check("midrst_rfd", int'(RFD), 0);
    repeat (25) cyc(1'b1, 1'b0, 4'd0);
    check("midrst_no_output", exp_q.size(), 0);

    // Clean frame after reset
    for (int i = 0; i < NN; i++) f[i] = '0;
    f[13] = 4'd1;
    es = '{4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12};
    send_frame(f, es, 1'b0, NS, -1);

    // NGRST during DUMP after three syndromes
    send_frame(f, es, 1'b0, 3, -1);
    #1;
    check("pre_ngrst_rdy", int'(RDY), 1);
    check("pre_ngrst_errdet", int'(ERRDET), 1);
    #1 NGRST = 1'b0;
    #1;
    check("ngrst_rdy", int'(RDY), 0);
    check("ngrst_done", int'(DONE), 0);
    check("ngrst_errdet", int'(ERRDET), 0);
    check("ngrst_syndout", int'(SYNDOUT), 0);
    check("ngrst_rfs", int'(RFS), 1);
    @(negedge CLK);
    NGRST = 1'b1;
    repeat (25) cyc(1'b1, 1'b0, 4'd0);

    // Frame after async reset
    f[13] = 4'd0; f[14] = 4'd1;
    es = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    send_frame(f, es, 1'b0, NS, -1);
    repeat (4) cyc(1'b1, 1'b0, 4'd0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
